pixel_norm_writer: RTL

Sits directly downstream of the camera capture and pixel-binning stage. It consumes each completed row of 32 binned R/G/B sums from the ping-pong banks, scales each sum to 8 bits with saturation, and writes the results into the classifier's 32x32 RGB input buffer. It raises a one-cycle frame-done pulse after row 31 is written. Runs entirely in the system clk domain.

---
 rtl/pixnorm_pkg.sv | 34 +++
 rtl/pixel_norm_writer_if.sv | 27 ++
 rtl/pixnorm_sat.sv | 14 +
 rtl/pixel_norm_writer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pixnorm_pkg.sv
// Shared types and constants for the pixel normalise-and-write block.
package pixnorm_pkg;

  localparam int ROWS  = 32;
  localparam int COLS  = 32;
  localparam int ROW_W = 5;
  localparam int COL_W = 5;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LAST
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // Coefficients sum to 256, so the 16-bit accumulator cannot overflow.
  function automatic logic [7:0] luma(input rgb8_t p);
    logic [15:0] acc;
    acc = 16'(LUMA_R) * {8'd0, p.r}
        + 16'(LUMA_G) * {8'd0, p.g}
        + 16'(LUMA_B) * {8'd0, p.b};
    return acc[15:8];
  endfunction

endpackage

// File: rtl/pixel_norm_writer_if.sv
// Upstream bank/row inputs and classifier-buffer write port of pixel_norm_writer.
interface pixel_norm_writer_if;
  import pixnorm_pkg::*;

  logic [1:0][COLS-1:0][15:0] r_data_i;
  logic [1:0][COLS-1:0][15:0] g_data_i;
  logic [1:0][COLS-1:0][15:0] b_data_i;
  logic [5:0]                 row_i;
  logic                       pxl_idle_i;
  logic                       wr_en_o;
  logic [9:0]                 wr_addr_o;
  logic [23:0]                wr_data_o;
  logic                       busy_o;
  logic                       frame_done_o;
  logic                       overrun_o;

  modport master (
    output r_data_i, g_data_i, b_data_i, row_i, pxl_idle_i,
    input  wr_en_o, wr_addr_o, wr_data_o, busy_o, frame_done_o, overrun_o
  );

  modport slave (
    input  r_data_i, g_data_i, b_data_i, row_i, pxl_idle_i,
    output wr_en_o, wr_addr_o, wr_data_o, busy_o, frame_done_o, overrun_o
  );

endinterface

// File: rtl/pixnorm_sat.sv
// Single-channel scale: logical right shift by the bin-area exponent, saturate to 8 bits.
module pixnorm_sat #(
  parameter int SHIFT = 6
) (
  input  logic [15:0] sum,
  output logic [7:0]  sat
);

  logic [15:0] scaled;

  assign scaled = sum >> SHIFT;
  assign sat    = (scaled > 16'd255) ? 8'hFF : scaled[7:0];

endmodule

// File: rtl/pixel_norm_writer.sv
// Drains completed binned rows into the classifier's 32x32 RGB buffer, one pixel per clk.
// Define PIXNORM_GRAY_EN to write replicated luma instead of RGB (adds one pipeline stage).
module pixel_norm_writer
  import pixnorm_pkg::*;
#(
  parameter int SHIFT = 6
) (
  input  logic            clk,
  input  logic            resetn,
  pixel_norm_writer_if.slave bus
);

  localparam logic [5:0]       ROWS_L   = 6'(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t           state, state_n;
  logic [5:0]       row_q;
  logic             idle_q;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] drain_row, drain_row_n, pending_row;
  logic             pending, overrun;
  logic             row_event, ev_taken, consume, sel;

  // A row change and an idle rise in the same cycle are one completion of row_q.
  assign row_event = ((bus.row_i != row_q) | (bus.pxl_idle_i & ~idle_q)) & (row_q < ROWS_L);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n     = state;
    col_n       = '0;
    drain_row_n = drain_row;
    ev_taken    = 1'b0;
    consume     = 1'b0;
    sel         = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_n     = DRAIN;
          drain_row_n = pending_row;
          consume     = 1'b1;
        end else if (row_event) begin
          state_n     = DRAIN;
          drain_row_n = row_q[ROW_W-1:0];
          ev_taken    = 1'b1;
        end
      end
      DRAIN: begin
        sel   = 1'b1;
        col_n = col + COL_W'(1);
        if (col == LAST_COL) begin
          col_n = '0;
          if (drain_row == LAST_ROW) begin
            state_n = LAST;
          end else if (pending) begin
            drain_row_n = pending_row;
            consume     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      LAST: begin
        if (pending) begin
          state_n     = DRAIN;
          drain_row_n = pending_row;
          consume     = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      col         <= '0;
      drain_row   <= '0;
      row_q       <= '0;
      idle_q      <= 1'b1;
      pending     <= 1'b0;
      pending_row <= '0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      drain_row <= drain_row_n;
      row_q     <= bus.row_i;
      idle_q    <= bus.pxl_idle_i;
      // A slot freed this very cycle may take the new row; otherwise a second wait is dropped.
      if (row_event && !ev_taken) begin
        if (pending && !consume) begin
          overrun <= 1'b1;
        end else begin
          pending     <= 1'b1;
          pending_row <= row_q[ROW_W-1:0];
        end
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

  // Upstream holds the completed bank stable, so the column is read straight from the inputs.
  rgb8_t pix;

  pixnorm_sat #(.SHIFT(SHIFT)) u_sat_r (.sum(bus.r_data_i[drain_row[0]][col]), .sat(pix.r));
  pixnorm_sat #(.SHIFT(SHIFT)) u_sat_g (.sum(bus.g_data_i[drain_row[0]][col]), .sat(pix.g));
  pixnorm_sat #(.SHIFT(SHIFT)) u_sat_b (.sum(bus.b_data_i[drain_row[0]][col]), .sat(pix.b));

  logic       s1_en, s1_fd;
  logic [9:0] s1_addr;
  rgb8_t      s1_pix;

  // NOTE: datapath registers are reset too, so the write port reads all-zero out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_en   <= 1'b0;
      s1_fd   <= 1'b0;
      s1_addr <= '0;
      s1_pix  <= '0;
    end else begin
      s1_en <= sel;
      s1_fd <= (state == LAST);
      if (sel) begin
        s1_addr <= {drain_row, col};
        s1_pix  <= pix;
      end
    end
  end

  logic wr_en;

`ifdef PIXNORM_GRAY_EN
  logic       s2_en, s2_fd;
  logic [9:0] s2_addr;
  logic [7:0] s2_y;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_en   <= 1'b0;
      s2_fd   <= 1'b0;
      s2_addr <= '0;
      s2_y    <= '0;
    end else begin
      s2_en <= s1_en;
      s2_fd <= s1_fd;
      if (s1_en) begin
        s2_addr <= s1_addr;
        s2_y    <= luma(s1_pix);
      end
    end
  end

  assign wr_en            = s2_en;
  assign bus.wr_addr_o    = s2_addr;
  assign bus.wr_data_o    = {s2_y, s2_y, s2_y};
  assign bus.frame_done_o = s2_fd;
`else
  assign wr_en            = s1_en;
  assign bus.wr_addr_o    = s1_addr;
  assign bus.wr_data_o    = s1_pix;
  assign bus.frame_done_o = s1_fd;
`endif

  assign bus.wr_en_o   = wr_en;
  assign bus.overrun_o = overrun;
  assign bus.busy_o    = (state != IDLE) | pending | wr_en;

endmodule
